hack_exec_ctrl: RTL

//   Run/halt/single-step sequencer for the Hack cpu. Generates the cpu clock

---
 rtl/hack_pkg.sv | 13 +
 rtl/hack_sat_cnt.sv | 24 ++
 rtl/hack_exec_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack cpu execution controller.
package hack_pkg;

   localparam int PW = 15;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      HALT  = 2'd1,
      RUN   = 2'd2,
      STEP  = 2'd3
   } exec_state_t;

endpackage

// File: rtl/hack_sat_cnt.sv
// Up-counter that sticks at all-ones instead of wrapping.
module hack_sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk50m,
   input  logic         srst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg;

   always_ff @(posedge clk50m) begin
      if (srst || clear) begin
         q_reg <= '0;
      end else if (inc && (q_reg != '1)) begin
         q_reg <= q_reg + W'(1);
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/hack_exec_ctrl.sv
// Run/halt/single-step sequencer: drives the Hack cpu clock enable and reset,
// stops on a pc breakpoint and counts retired instructions.
module hack_exec_ctrl
   import hack_pkg::*;
#(
   parameter int PW       = hack_pkg::PW,
   parameter int CW       = 32,
   parameter int RST_CYC  = 4,
   parameter int AUTO_RUN = 0
) (
   input  logic          clk50m,
   input  logic          rst,
   input  logic          soft_rst,
   input  logic          run_req,
   input  logic          halt_req,
   input  logic          step_req,
   input  logic          bp_en,
   input  logic [PW-1:0] bp_addr,
   input  logic [PW-1:0] pc,
   output logic          en25m,
   output logic          cpu_rst_n,
   output logic          running,
   output logic          halted,
   output logic          bp_hit,
   output logic [CW-1:0] instr_cnt
);

   localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);

   exec_state_t    state_reg, state_next;
   logic           en_reg, en_next;
   logic           rstn_reg, rstn_next;
   logic           bp_hit_reg, bp_hit_next;
   logic           skip_reg, skip_next;
   logic [RCW-1:0] rst_cnt_reg, rst_cnt_next;
   logic           running_reg, halted_reg;
   logic           bp_match;

   // skip_reg lets the instruction sitting on the breakpoint run after a resume
   assign bp_match = bp_en && (pc == bp_addr) && !skip_reg;

   always_comb begin
      state_next   = state_reg;
      en_next      = 1'b0;
      rstn_next    = rstn_reg;
      bp_hit_next  = bp_hit_reg;
      skip_next    = skip_reg;
      rst_cnt_next = rst_cnt_reg;

      if (soft_rst) begin
         state_next   = RESET;
         rstn_next    = 1'b0;
         bp_hit_next  = 1'b0;
         skip_next    = 1'b0;
         rst_cnt_next = '0;
      end else begin
         case (state_reg)
            RESET: begin
               if (rst_cnt_reg == RST_LAST) begin
                  rstn_next  = 1'b1;
                  state_next = (AUTO_RUN != 0) ? RUN : HALT;
               end else begin
                  rst_cnt_next = rst_cnt_reg + 1'b1;
               end
            end
            HALT: begin
               if (!halt_req && (step_req || run_req)) begin
                  state_next  = step_req ? STEP : RUN;
                  bp_hit_next = 1'b0;
                  skip_next   = 1'b1;
               end
            end
            RUN: begin
               // a pulse already high simply falls; new pulses only start from low
               if (halt_req) begin
                  state_next = HALT;
               end else if (!en_reg) begin
                  if (bp_match) begin
                     state_next  = HALT;
                     bp_hit_next = 1'b1;
                  end else begin
                     en_next   = 1'b1;
                     skip_next = 1'b0;
                  end
               end
            end
            STEP: begin
               en_next    = 1'b1;
               skip_next  = 1'b0;
               state_next = HALT;
            end
            default: begin
               state_next = RESET;
            end
         endcase
      end
   end

   always_ff @(posedge clk50m) begin
      if (rst) begin
         state_reg   <= RESET;
         en_reg      <= 1'b0;
         rstn_reg    <= 1'b0;
         bp_hit_reg  <= 1'b0;
         skip_reg    <= 1'b0;
         rst_cnt_reg <= '0;
         running_reg <= 1'b0;
         halted_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         en_reg      <= en_next;
         rstn_reg    <= rstn_next;
         bp_hit_reg  <= bp_hit_next;
         skip_reg    <= skip_next;
         rst_cnt_reg <= rst_cnt_next;
         running_reg <= (state_next == RUN);
         halted_reg  <= (state_next == HALT);
      end
   end

   hack_sat_cnt #(
      .W(CW)
   ) u_instr_cnt (
      .clk50m (clk50m),
      .srst   (rst),
      .clear  (soft_rst),
      .inc    (en_reg),
      .q      (instr_cnt)
   );

   assign en25m     = en_reg;
   assign cpu_rst_n = rstn_reg;
   assign running   = running_reg;
   assign halted    = halted_reg;
   assign bp_hit    = bp_hit_reg;

endmodule
